step_probe: RTL and testbench

Parametrised single-step and debug-display unit for the board-level CPU harness. It debounces the step push-button into a one-cycle clock-enable pulse for the CPU core, rather than a derived clock. It snapshots up to 2^CH_W probe words plus their ZF/OF flags on every step, and drives the 8 board LEDs with a selected byte or flag page. The byte shown is chosen manually, or by an auto-scan that cycles through all bytes.

---
 rtl/step_probe.sv | 160 ++++++++++++++++
 tb/tb_step_probe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/step_probe.sv
// step_probe: single-step and debug-display unit for the board CPU harness.
//
// The raw step button is synchronised and debounced. Each debounced press
// becomes a one-cycle clock-enable pulse, `step`. The pulse snapshots every
// probe word and its flags and advances `step_cnt`. The 8 LEDs show one byte
// page, or the flag page, of the selected channel. The source is either the
// live inputs or the snapshot. The page is picked manually or by an auto-scan.
//
// Ports
//   clk_100MHz   system clock, rising edge
//   rst          asynchronous active-low reset
//   btn          raw bouncy step button (asynchronous)
//   probe_data   NCH live probe words, channel c at [c*DATA_W +: DATA_W]
//   probe_flags  per channel c: bit 2c+1 = ZF, bit 2c = OF
//   ch_sel       channel to display
//   byte_sel     manual page (any value >= NB selects the flag page)
//   auto         1 = auto-scan pages, byte_sel ignored
//   freeze       1 = display snapshot, 0 = display live inputs
//   step         registered one-cycle step pulse
//   step_cnt     number of steps issued, wraps at 16 bits
//   led          registered display byte
module step_probe #(
    parameter int DATA_W      = 32,
    parameter int CH_W        = 1,
    parameter int DEB_CYCLES  = 1000000,
    parameter int SCAN_CYCLES = 50000000
) (
    input  logic                              clk_100MHz,
    input  logic                              rst,
    input  logic                              btn,
    input  logic [(2**CH_W)*DATA_W-1:0]       probe_data,
    input  logic [(2**CH_W)*2-1:0]            probe_flags,
    input  logic [CH_W-1:0]                   ch_sel,
    input  logic [2:0]                        byte_sel,
    input  logic                              auto,
    input  logic                              freeze,
    output logic                              step,
    output logic [15:0]                       step_cnt,
    output logic [7:0]                        led
);

    localparam int NCH    = 2**CH_W;
    localparam int NB     = DATA_W / 8;
    localparam int DCNT_W = $clog2(DEB_CYCLES);
    localparam int SCNT_W = $clog2(SCAN_CYCLES);

    // ---------------- synchroniser ----------------
    logic sync0, btn_s;
    // vld fills with ones once the sync chain carries real samples of btn.
    logic [1:0] vld;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            sync0 <= 1'b0;
            btn_s <= 1'b0;
            vld   <= 2'b00;
        end else begin
            sync0 <= btn;
            btn_s <= sync0;
            vld   <= {vld[0], 1'b1};
        end
    end

    // ---------------- debouncer and step ----------------
    logic              stable;
    logic [DCNT_W-1:0] dcnt;
    logic              accept;
    // armed is cleared by reset and set only once the button has been seen
    // released. A press already held through reset therefore issues no step.
    logic              armed;

    assign accept = (btn_s != stable) && (dcnt == DCNT_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            dcnt   <= '0;
            step   <= 1'b0;
            armed  <= 1'b0;
        end else begin
            if (btn_s == stable) begin
                dcnt <= '0;
            end else if (accept) begin
                stable <= btn_s;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
            if (vld[1] && !btn_s)
                armed <= 1'b1;
            // Pulse only on the 0->1 transition of the debounced level.
            step <= accept && btn_s && armed;
        end
    end

    // ---------------- snapshot and step counter ----------------
    logic [NCH*DATA_W-1:0] snap_data;
    logic [NCH*2-1:0]      snap_flags;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            snap_data  <= '0;
            snap_flags <= '0;
            step_cnt   <= 16'h0000;
        end else if (step) begin
            snap_data  <= probe_data;
            snap_flags <= probe_flags;
            step_cnt   <= step_cnt + 16'h0001;
        end
    end

    // ---------------- auto-scan ----------------
    logic [2:0]        pg;
    logic [SCNT_W-1:0] scnt;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            pg   <= 3'd0;
            scnt <= '0;
        end else if (!auto) begin
            // Leaving auto mode always restarts the scan at page 0.
            pg   <= 3'd0;
            scnt <= '0;
        end else if (scnt == SCNT_W'(SCAN_CYCLES - 1)) begin
            scnt <= '0;
            pg   <= (pg == 3'(NB)) ? 3'd0 : pg + 3'd1;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    // ---------------- display ----------------
    logic [2:0]        page;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] shifted;
    logic [1:0]        fl;
    logic [7:0]        led_d;

    always_comb begin
        page    = auto ? pg : byte_sel;
        word    = freeze ? snap_data[ch_sel*DATA_W +: DATA_W]
                         : probe_data[ch_sel*DATA_W +: DATA_W];
        fl      = freeze ? snap_flags[ch_sel*2 +: 2]
                         : probe_flags[ch_sel*2 +: 2];
        shifted = word >> {page, 3'b000};
        led_d   = 8'h00;
        if (page >= 3'(NB))
            led_d = {fl[1], 6'b000000, fl[0]};
        else
            led_d = shifted[7:0];
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst)
            led <= 8'h00;
        else
            led <= led_d;
    end

endmodule

// File: tb/tb_step_probe.sv
// Directed bench for step_probe with DEB_CYCLES=4, SCAN_CYCLES=3.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_step_probe;

    localparam int DATA_W = 32;
    localparam int CH_W   = 1;

    logic        clk_100MHz;
    logic        rst;
    logic        btn;
    logic [63:0] probe_data;
    logic [3:0]  probe_flags;
    logic [0:0]  ch_sel;
    logic [2:0]  byte_sel;
    logic        auto;
    logic        freeze;
    logic        step;
    logic [15:0] step_cnt;
    logic [7:0]  led;

    int n_asrt = 0;
    int n_fail = 0;

    step_probe #(
        .DATA_W(DATA_W), .CH_W(CH_W), .DEB_CYCLES(4), .SCAN_CYCLES(3)
    ) dut (
        .clk_100MHz(clk_100MHz), .rst(rst), .btn(btn),
        .probe_data(probe_data), .probe_flags(probe_flags),
        .ch_sel(ch_sel), .byte_sel(byte_sel), .auto(auto), .freeze(freeze),
        .step(step), .step_cnt(step_cnt), .led(led)
    );

    // clock / reset
    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    // Runs n cycles with btn unchanged; reports pulse count and first pulse index.
    task automatic watch(input int n, output int pulses, output int first_at);
        pulses   = 0;
        first_at = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100MHz);
            if (step === 1'b1) begin
                if (pulses == 0) first_at = i;
                pulses++;
            end
        end
    endtask

    task automatic press_release();
        btn = 1'b1;
        tick(12);
        btn = 1'b0;
        tick(12);
    endtask

    int         pulses, first_at;
    logic [7:0] scan_exp [18];

    initial begin
        // 1. reset with X inputs
        rst = 1'b0;
        btn = 1'bx; probe_data = 'x; probe_flags = 'x;
        ch_sel = 'x; byte_sel = 'x; auto = 1'bx; freeze = 1'bx;
        tick(3);
        chk("reset_step", {15'd0, step}, 16'h0000);
        chk("reset_cnt", step_cnt, 16'h0000);
        chk("reset_led", {8'd0, led}, 16'h0000);
        btn = 1'b0; probe_data = '0; probe_flags = '0;
        ch_sel = 1'b0; byte_sel = 3'd0; auto = 1'b0; freeze = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(5);
        chk("post_reset_step", {15'd0, step}, 16'h0000);
        chk("post_reset_cnt", step_cnt, 16'h0000);
        chk("post_reset_led", {8'd0, led}, 16'h0000);

        // 2a. clean press: pulse seen after edge 5 of the press
        btn = 1'b1;
        watch(20, pulses, first_at);
        chk("clean_pulses", 16'(pulses), 16'd1);
        chk("clean_latency", 16'(first_at), 16'd5);
        chk("clean_cnt", step_cnt, 16'd1);
        btn = 1'b0;
        watch(20, pulses, first_at);
        chk("release_pulses", 16'(pulses), 16'd0);
        chk("release_cnt", step_cnt, 16'd1);

        // 2b. bouncing press 1,1,0,0 then held: pulse 5 edges after final rise
        pulses = 0; first_at = -1;
        for (int i = 0; i < 30; i++) begin
            btn = (i < 2) || (i >= 4);
            @(negedge clk_100MHz);
            if (step === 1'b1) begin
                if (pulses == 0) first_at = i;
                pulses++;
            end
        end
        chk("bounce_pulses", 16'(pulses), 16'd1);
        chk("bounce_latency", 16'(first_at), 16'd9);
        chk("bounce_cnt", step_cnt, 16'd2);
        btn = 1'b0;
        tick(12);

        // 3. snapshot and freeze
        probe_data = {32'hCAFEF00D, 32'h12345678};
        press_release();
        chk("snap_cnt", step_cnt, 16'd3);
        probe_data = '0;
        freeze = 1'b1; ch_sel = 1'b1; byte_sel = 3'd3;
        tick(1);
        chk("frz_ch1_b3", {8'd0, led}, 16'h00CA);
        ch_sel = 1'b0; byte_sel = 3'd0;
        tick(1);
        chk("frz_ch0_b0", {8'd0, led}, 16'h0078);
        byte_sel = 3'd2;
        tick(1);
        chk("frz_ch0_b2", {8'd0, led}, 16'h0034);
        freeze = 1'b0;
        tick(1);
        chk("live_zero", {8'd0, led}, 16'h0000);

        // 4. flag page
        probe_flags = 4'b1001;
        byte_sel = 3'd4; ch_sel = 1'b1;
        tick(1);
        chk("flag_ch1", {8'd0, led}, 16'h0080);
        ch_sel = 1'b0;
        tick(1);
        chk("flag_ch0", {8'd0, led}, 16'h0001);
        byte_sel = 3'd7;
        tick(1);
        chk("flag_sel7_ch0", {8'd0, led}, 16'h0001);
        ch_sel = 1'b1;
        tick(1);
        chk("flag_sel7_ch1", {8'd0, led}, 16'h0080);

        // 5. auto-scan on live channel 0
        probe_data = {32'h55667788, 32'hA1B2C3D4};
        ch_sel = 1'b0; byte_sel = 3'd1;
        scan_exp = '{8'hD4, 8'hD4, 8'hD4, 8'hC3, 8'hC3, 8'hC3,
                     8'hB2, 8'hB2, 8'hB2, 8'hA1, 8'hA1, 8'hA1,
                     8'h01, 8'h01, 8'h01, 8'hD4, 8'hD4, 8'hD4};
        auto = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_100MHz);
            chk($sformatf("scan_%0d", i), {8'd0, led}, {8'd0, scan_exp[i]});
        end
        auto = 1'b0;
        tick(1);
        chk("scan_off_manual", {8'd0, led}, 16'h00C3);
        tick(4);
        auto = 1'b1;
        tick(1);
        chk("scan_restart_p0", {8'd0, led}, 16'h00D4);
        auto = 1'b0;
        tick(2);

        // 6a. reset two cycles into a debounce count, btn held high
        btn = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(1);
        chk("midrst_cnt", step_cnt, 16'd0);
        chk("midrst_led", {8'd0, led}, 16'h0000);
        rst = 1'b1;
        watch(20, pulses, first_at);
        chk("midrst_no_step", 16'(pulses), 16'd0);
        btn = 1'b0;
        tick(12);
        btn = 1'b1;
        watch(12, pulses, first_at);
        chk("rearm_pulses", 16'(pulses), 16'd1);
        chk("rearm_cnt", step_cnt, 16'd1);
        btn = 1'b0;
        tick(12);

        // 6b. counter wrap: hold step high to issue steps back to back
        force dut.step = 1'b1;
        tick(65534);
        force dut.step = 1'b0;
        tick(1);
        chk("cnt_ffff", step_cnt, 16'hFFFF);
        force dut.step = 1'b1;
        tick(1);
        force dut.step = 1'b0;
        tick(1);
        chk("cnt_wrap", step_cnt, 16'h0000);
        release dut.step;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
